// File: rtl/dmem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_lsu : load/store unit between the MEM stage and a variable-latency    |
// |            word SRAM. Optional misaligned trap: DMEM_LSU_MISALIGN_TRAP_EN. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_lsu #(
  parameter int ADDR_W   = 30,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_dmtype,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              cpu_misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] C_CNT_LAST = 16'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        dmtype_q, dmtype_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misalign_q, misalign_d;

  logic              is_half, is_byte, misaligned;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new, load_ext;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;

  // Request decode: byte-lane enables and lane-replicated store data
  always_comb begin
    is_half = (cpu_dmtype == 3'b001) || (cpu_dmtype == 3'b010);
    is_byte = (cpu_dmtype == 3'b011) || (cpu_dmtype == 3'b100);
    if (is_byte) begin
      be_new    = 4'b0001 << cpu_addr[1:0];
      wdata_new = {4{cpu_wdata[7:0]}};
    end else if (is_half) begin
      be_new    = cpu_addr[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{cpu_wdata[15:0]}};
    end else begin
      be_new    = 4'b1111;
      wdata_new = cpu_wdata;
    end
  end

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  assign misaligned = (is_half && cpu_addr[0]) ||
                      (!is_half && !is_byte && (cpu_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Load extraction uses the latched lane and type, not the live CPU inputs
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (dmtype_q)
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = {16'h0000, half_sel};
      3'b011:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    dmtype_d   = dmtype_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d     = cpu_we;
          addr_d   = cpu_addr[ADDR_W+1:2];
          be_d     = be_new;
          wdata_d  = wdata_new;
          dmtype_d = cpu_dmtype;
          lane_d   = cpu_addr[1:0];
          cnt_d    = 16'd0;
          if (misaligned) begin
            state_d    = S_DONE;
            misalign_d = 1'b1;
            rdata_d    = 32'h0;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // A ready in the final watchdog cycle still completes normally
        if (mem_ready) begin
          state_d = S_DONE;
          rdata_d = load_ext;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      dmtype_q   <= 3'b000;
      lane_q     <= 2'b00;
      cnt_q      <= 16'd0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      dmtype_q   <= dmtype_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  assign cpu_stall    = reset & cpu_req & (state_q != S_DONE);
  assign cpu_rdata    = rdata_q;
  assign cpu_err      = err_q;
  assign cpu_misalign = misalign_q;
  assign mem_req      = (state_q == S_ACCESS);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;

endmodule
`default_nettype wire
